// File: rtl/axi_wr_responder_pkg.sv
// Shared definitions for the AXI write responder.
//   - AXI burst type encodings (FIXED / INCR / WRAP / reserved)
//   - AXI response encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   - Responder FSM state enum (IDLE / DATA / RESP)
//   - resp_merge(): combines two responses by severity
package axi_wr_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  // Severity order DECERR > SLVERR > OKAY. EXOKAY is only kept when both
  // sides report it; this slave never produces it itself.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) begin
      return RESP_DECERR;
    end else if (a == RESP_SLVERR || b == RESP_SLVERR) begin
      return RESP_SLVERR;
    end else if (a == RESP_EXOKAY && b == RESP_EXOKAY) begin
      return RESP_EXOKAY;
    end else begin
      return RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/axi_burst_addr_next.sv
// Combinational AXI next-beat address generator (shared with the read side).
// Ports:
//   addr      in   current beat byte address
//   size      in   log2 bytes per beat (AxSIZE)
//   len       in   beats minus 1 (AxLEN)
//   burst     in   burst type (AxBURST)
//   addr_next out  byte address of the following beat
module axi_burst_addr_next
  import axi_wr_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] addr_next
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step       = ADDR_W'(1) << size;
    incr_addr  = addr + step;
    wrap_bytes = ADDR_W'({1'b0, len} + 1'b1) << size;
    wrap_mask  = wrap_bytes - ADDR_W'(1);
    addr_next  = addr;
    case (burst)
      BURST_FIXED: addr_next = addr;
      BURST_INCR:  addr_next = incr_addr;
      // Keep the bits above the wrap boundary, advance only inside it.
      BURST_WRAP:  addr_next = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     addr_next = addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_responder.sv
// AXI4 write-path responder: one transaction at a time, AW -> W beats -> B.
// Every accepted W beat produces a registered one-cycle write on a simple
// synchronous memory port.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   aw*                        write address channel (awready registered)
//   w*                         write data channel (wready registered)
//   b*                         write response channel (all registered)
//   mem_we/addr/wdata/be       memory write port, pulses 1 cycle after a W beat
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Ready/valid outputs of this block only depend on the FSM
// state, so they never combinationally depend on the opposite side.
module axi_wr_responder
  import axi_wr_responder_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_AXI_LEN_WIDTH  = 8,
  parameter int MEM_ADDR_WIDTH   = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [C_AXI_ID_WIDTH-1:0]     awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   awaddr,
  input  logic [C_AXI_LEN_WIDTH-1:0]    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                          wlast,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [C_AXI_ID_WIDTH-1:0]     bid,
  output logic [1:0]                    bresp,
  output logic                          mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]   mem_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] mem_be
);

  localparam int STRB_W  = C_AXI_DATA_WIDTH / 8;
  localparam int OFF     = $clog2(STRB_W);
  // Any set address bit at or above this position lies outside the RAM.
  localparam int DEC_LSB = MEM_ADDR_WIDTH + OFF;

  state_t                        state_q, state_d;
  logic [C_AXI_ID_WIDTH-1:0]     id_q, id_d;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_AXI_LEN_WIDTH-1:0]    len_q, len_d;
  logic [2:0]                    size_q, size_d;
  logic [1:0]                    burst_q, burst_d;
  logic [C_AXI_LEN_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
  logic [1:0]                    err_q, err_d;
  logic                          suppress_q, suppress_d;

  logic                          awready_q, awready_d;
  logic                          wready_q, wready_d;
  logic                          bvalid_q, bvalid_d;
  logic [C_AXI_ID_WIDTH-1:0]     bid_q, bid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [C_AXI_DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]             mem_be_q, mem_be_d;

  logic [C_AXI_ADDR_WIDTH-1:0]   addr_next;
  logic                          aw_hs, w_hs, b_hs;
  logic                          aw_err;
  logic                          wrap_len_ok;
  logic                          last_beat;
  logic                          dec_err;
  logic [1:0]                    beat_err;
  logic [1:0]                    err_merged;

  axi_burst_addr_next #(
    .ADDR_W (C_AXI_ADDR_WIDTH),
    .LEN_W  (C_AXI_LEN_WIDTH)
  ) u_addr_next (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .addr_next (addr_next)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    suppress_d  = suppress_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;

    aw_hs = awvalid & awready_q;
    w_hs  = wvalid & wready_q;
    b_hs  = bvalid_q & bready;

    wrap_len_ok = (awlen == C_AXI_LEN_WIDTH'(1)) || (awlen == C_AXI_LEN_WIDTH'(3)) ||
                  (awlen == C_AXI_LEN_WIDTH'(7)) || (awlen == C_AXI_LEN_WIDTH'(15));
    // These errors make the whole burst unsafe to write, so they also
    // suppress every memory write of the transaction.
    aw_err = (awburst == BURST_RSVD) || (awsize > 3'(OFF)) ||
             ((awburst == BURST_WRAP) && !wrap_len_ok);

    last_beat  = (beat_cnt_q == len_q);
    dec_err    = |addr_q[C_AXI_ADDR_WIDTH-1:DEC_LSB];
    beat_err   = dec_err ? RESP_DECERR :
                 (wlast != last_beat) ? RESP_SLVERR : RESP_OKAY;
    err_merged = resp_merge(err_q, beat_err);

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d       = awid;
          addr_d     = awaddr;
          len_d      = awlen;
          size_d     = awsize;
          burst_d    = awburst;
          beat_cnt_d = '0;
          err_d      = aw_err ? RESP_SLVERR : RESP_OKAY;
          suppress_d = aw_err;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          // A decode error only drops this beat's write; the rest of the
          // burst may still land in the RAM.
          mem_we_d    = ~suppress_q & ~dec_err;
          mem_addr_d  = addr_q[OFF +: MEM_ADDR_WIDTH];
          mem_wdata_d = wdata;
          mem_be_d    = wstrb;
          err_d       = err_merged;
          addr_d      = addr_next;
          beat_cnt_d  = beat_cnt_q + C_AXI_LEN_WIDTH'(1);
          // Termination is by count only; wlast just feeds the error flag.
          if (last_beat) begin
            bid_d   = id_q;
            bresp_d = err_merged;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Channel readies/valid are registered copies of the next state.
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= RESP_OKAY;
      suppress_q  <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      suppress_q  <= suppress_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule
